// File: rtl/led_strip_driver_if.sv
// led_strip_driver_if
//   Read port between the LED colour buffer and the strand driver.
//   master : driver side, issues the read address and consumes colour bytes.
//   slave  : buffer side, returns GRB bytes plus color_valid for that address.
// Signals:
//   next_led_request_address  buffer read address (driven by master)
//   green_in/red_in/blue_in   colour bytes for the current address
//   color_valid               colour bytes correspond to the current address
interface led_strip_driver_if #(
  parameter int LED_ADDRESS_WIDTH = 10
);
  logic [LED_ADDRESS_WIDTH-1:0] next_led_request_address;
  logic [7:0]                   green_in;
  logic [7:0]                   red_in;
  logic [7:0]                   blue_in;
  logic                         color_valid;

  modport master (
    output next_led_request_address,
    input  green_in,
    input  red_in,
    input  blue_in,
    input  color_valid
  );

  modport slave (
    input  next_led_request_address,
    output green_in,
    output red_in,
    output blue_in,
    output color_valid
  );
endinterface

// File: rtl/led_strip_driver.sv
// led_strip_driver
//   Serializes 24-bit GRB words from the LED colour buffer onto a WS2812-style
//   one-wire strand (pulse-width coded bits, MSB first), then holds the line
//   low for a latch gap and pulses frame_done.
// Ports:
//   clk_led     LED clock
//   rst         asynchronous, active-high reset
//   enable      run frames continuously while high
//   buf_if      colour buffer read port (address out, GRB + color_valid in)
//   strand_out  serial data to the strand
//   busy        high whenever the FSM is not idle
//   frame_done  one-cycle pulse when the latch gap ends
//
// state | meaning
// IDLE  | address held at 0, waiting for enable
// FETCH | waiting for color_valid on the requested address
// SEND  | shifting out the 24 bits of the current LED
// GAP   | strand held low for the latch/reset interval
module led_strip_driver #(
  parameter int NUM_LEDS          = 50,
  parameter int LED_ADDRESS_WIDTH = 10,
  parameter int BIT_PERIOD        = 125,
  parameter int T0H               = 40,
  parameter int T1H               = 80,
  parameter int RESET_CYCLES      = 6000
) (
  input  logic                    clk_led,
  input  logic                    rst,
  input  logic                    enable,
  led_strip_driver_if.master      buf_if,
  output logic                    strand_out,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int CNT_MAX = (BIT_PERIOD > RESET_CYCLES) ? BIT_PERIOD : RESET_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int LIW     = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam logic [CW-1:0]  BIT_LAST = CW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0]  GAP_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0]  HIGH_0   = CW'(T0H);
  localparam logic [CW-1:0]  HIGH_1   = CW'(T1H);
  localparam logic [LIW-1:0] LED_LAST = LIW'(NUM_LEDS - 1);

  logic [1:0]     state_q, state_d;
  logic [23:0]    shift_q, shift_d;
  logic [4:0]     bit_q, bit_d;
  logic [CW-1:0]  cyc_q, cyc_d;
  logic [LIW-1:0] led_q, led_d;     // LED currently on the wire
  logic [LIW-1:0] addr_q, addr_d;   // LED requested from the buffer (prefetch)
  logic           strand_q, strand_d;
  logic           busy_q;
  logic           done_q, done_d;

  logic           load;
  logic [CW-1:0]  cyc_inc;
  logic [CW-1:0]  high_len;
  logic [LIW-1:0] addr_next;
  logic [23:0]    word_in;

  assign cyc_inc   = cyc_q + CW'(1);
  assign high_len  = shift_q[23] ? HIGH_1 : HIGH_0;
  assign addr_next = (addr_q == LED_LAST) ? '0 : addr_q + LIW'(1);
  assign word_in   = {buf_if.green_in, buf_if.red_in, buf_if.blue_in};

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    cyc_d    = cyc_q;
    led_d    = led_q;
    addr_d   = addr_q;
    strand_d = 1'b0;
    done_d   = 1'b0;
    load     = 1'b0;

    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (enable) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (buf_if.color_valid) load = 1'b1;
      end
      S_SEND: begin
        if (cyc_q != BIT_LAST) begin
          // registered output: the value for the next cycle's position in the bit
          cyc_d    = cyc_inc;
          strand_d = (cyc_inc < high_len);
        end else if (bit_q != 5'd23) begin
          shift_d  = {shift_q[22:0], 1'b0};
          bit_d    = bit_q + 5'd1;
          cyc_d    = '0;
          strand_d = 1'b1;
        end else if (led_q == LED_LAST) begin
          state_d = S_GAP;
          cyc_d   = '0;
        end else if (buf_if.color_valid) begin
          load = 1'b1;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_GAP: begin
        if (cyc_q == GAP_LAST) begin
          done_d  = 1'b1;
          cyc_d   = '0;
          state_d = enable ? S_FETCH : S_IDLE;
        end else begin
          cyc_d = cyc_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Loading a word starts its first bit high on the same edge and
    // immediately requests the following LED so the buffer latency is hidden.
    if (load) begin
      state_d  = S_SEND;
      shift_d  = word_in;
      bit_d    = '0;
      cyc_d    = '0;
      strand_d = 1'b1;
      led_d    = addr_q;
      addr_d   = addr_next;
    end
  end

  always_ff @(posedge clk_led or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      bit_q    <= '0;
      cyc_q    <= '0;
      led_q    <= '0;
      addr_q   <= '0;
      strand_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      cyc_q    <= cyc_d;
      led_q    <= led_d;
      addr_q   <= addr_d;
      strand_q <= strand_d;
      busy_q   <= (state_d != S_IDLE);
      done_q   <= done_d;
    end
  end

  assign buf_if.next_led_request_address = LED_ADDRESS_WIDTH'(addr_q);
  assign strand_out = strand_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_led_strip_driver.sv
module tb_led_strip_driver;
  localparam int NL = 3;
  localparam int BP = 10;
  localparam int T0 = 3;
  localparam int T1 = 7;
  localparam int RC = 20;
  localparam int AW = 10;

  typedef struct {
    logic [71:0] data;   // {LED0, LED1, LED2} GRB words
    int          stall;  // extra cycles color_valid is held low before LED 1
    int          ones;   // hand-counted 1-bits in data
    int          len;    // first rise to frame_done, in cycles
  } vec_t;

  logic clk_led = 1'b0;
  logic rst     = 1'b1;
  logic en0     = 1'b0;
  logic en1     = 1'b0;
  logic hold    = 1'b0;
  logic strand0, busy0, done0;
  logic strand1, busy1, done1;

  always #5 clk_led = ~clk_led;

  led_strip_driver_if #(.LED_ADDRESS_WIDTH(AW)) bif0 ();
  led_strip_driver_if #(.LED_ADDRESS_WIDTH(AW)) bif1 ();

  led_strip_driver #(
    .NUM_LEDS(NL), .LED_ADDRESS_WIDTH(AW), .BIT_PERIOD(BP),
    .T0H(T0), .T1H(T1), .RESET_CYCLES(RC)
  ) u0 (
    .clk_led(clk_led), .rst(rst), .enable(en0), .buf_if(bif0),
    .strand_out(strand0), .busy(busy0), .frame_done(done0)
  );

  led_strip_driver #(
    .NUM_LEDS(1), .LED_ADDRESS_WIDTH(AW), .BIT_PERIOD(BP),
    .T0H(T0), .T1H(T1), .RESET_CYCLES(RC)
  ) u1 (
    .clk_led(clk_led), .rst(rst), .enable(en1), .buf_if(bif1),
    .strand_out(strand1), .busy(busy1), .frame_done(done1)
  );

  // Buffer models: colour valid once the address has been stable 2 cycles.
  logic [23:0]   mem0 [NL];
  logic [23:0]   mem1;
  logic [23:0]   word0;
  logic [AW-1:0] a0_prev = '0;
  logic [AW-1:0] a1_prev = '0;
  int            st0 = 0;
  int            st1 = 0;

  always @(posedge clk_led) begin
    if (bif0.next_led_request_address != a0_prev) st0 <= 0;
    else if (st0 < 2) st0 <= st0 + 1;
    a0_prev <= bif0.next_led_request_address;
    if (bif1.next_led_request_address != a1_prev) st1 <= 0;
    else if (st1 < 2) st1 <= st1 + 1;
    a1_prev <= bif1.next_led_request_address;
  end

  assign word0 = (bif0.next_led_request_address < AW'(NL)) ?
                 mem0[bif0.next_led_request_address[1:0]] : 24'h0;
  assign bif0.green_in    = word0[23:16];
  assign bif0.red_in      = word0[15:8];
  assign bif0.blue_in     = word0[7:0];
  assign bif0.color_valid = (st0 >= 2) && !hold;
  assign bif1.green_in    = mem1[23:16];
  assign bif1.red_in      = mem1[15:8];
  assign bif1.blue_in     = mem1[7:0];
  assign bif1.color_valid = (st1 >= 2);

  // Strand monitors, sampled on the falling edge.
  int   ncyc = 0;
  int   rises[$], widths[$], addr_vals[$], addr_times[$], done_times[$], busy_at_done[$];
  int   rises1[$], widths1[$], done1_times[$];
  int   en_rise_n = 0;
  int   addr1_nz = 0;
  int   hw0 = 0, hw1 = 0;
  logic s0p = 1'b0, s1p = 1'b0, en0p = 1'b0;
  logic [AW-1:0] a0p = '0;

  initial forever begin
    @(negedge clk_led);
    ncyc++;
    if (strand0) begin
      if (!s0p) begin rises.push_back(ncyc); hw0 = 1; end
      else hw0++;
    end else if (s0p) widths.push_back(hw0);
    s0p = strand0;
    if (bif0.next_led_request_address != a0p) begin
      addr_vals.push_back(int'(bif0.next_led_request_address));
      addr_times.push_back(ncyc);
    end
    a0p = bif0.next_led_request_address;
    if (done0) begin
      done_times.push_back(ncyc);
      busy_at_done.push_back(int'(busy0));
    end
    if (en0 && !en0p) en_rise_n = ncyc;
    en0p = en0;
    if (strand1) begin
      if (!s1p) begin rises1.push_back(ncyc); hw1 = 1; end
      else hw1++;
    end else if (s1p) widths1.push_back(hw1);
    s1p = strand1;
    if (bif1.next_led_request_address != '0) addr1_nz++;
    if (done1) done1_times.push_back(ncyc);
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic ck(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic ck_data(input string name, input logic [71:0] got, input logic [71:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  function automatic int qsize(input int which);
    case (which)
      0:       return rises.size();
      1:       return done_times.size();
      2:       return rises1.size();
      default: return done1_times.size();
    endcase
  endfunction

  // Polls at posedge+2 so it never races the falling-edge monitor.
  task automatic wait_q(input string name, input int which, input int n, input int budget);
    int k;
    k = 0;
    while (qsize(which) < n && k < budget) begin
      @(posedge clk_led); #2;
      k++;
    end
    ck(name, int'(qsize(which) >= n), 1);
  endtask

  function automatic logic [71:0] decode(input int q[$], input int off, input int n);
    logic [71:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = {r[70:0], (q[off+i] == T1)};
    return r;
  endfunction

  function automatic int count_w(input int q[$], input int off, input int n, input int w);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) if (q[off+i] == w) c++;
    return c;
  endfunction

  task automatic clear_mon();
    rises.delete(); widths.delete(); addr_vals.delete(); addr_times.delete();
    done_times.delete(); busy_at_done.delete();
    rises1.delete(); widths1.delete(); done1_times.delete();
    addr1_nz = 0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int bad;
    for (int i = 0; i < NL; i++) mem0[i] = v.data[71-24*i -: 24];
    clear_mon();
    @(posedge clk_led); #2;
    en0 = 1'b1;
    wait_q("first_rise", 0, 1, 50);
    en0 = 1'b0;
    if (v.stall > 0) begin
      // keep color_valid low from the LED 0 end edge for v.stall edges
      hold = 1'b1;
      repeat (238 + v.stall) @(posedge clk_led);
      #2;
      hold = 1'b0;
    end
    wait_q("frame_done", 1, 1, 2000);
    repeat (5) @(posedge clk_led);
    #2;
    ck($sformatf("v%0d_pulse_count", idx), widths.size(), 72);
    ck($sformatf("v%0d_done_cycles", idx), done_times.size(), 1);
    ck($sformatf("v%0d_addr_changes", idx), addr_vals.size(), 3);
    ck($sformatf("v%0d_busy_idle", idx), int'(busy0), 0);
    if (widths.size() >= 72 && rises.size() >= 72 && done_times.size() >= 1 && addr_vals.size() >= 3) begin
      ck($sformatf("v%0d_start_latency", idx), rises[0] - en_rise_n, 2);
      ck_data($sformatf("v%0d_data", idx), decode(widths, 0, 72), v.data);
      ck($sformatf("v%0d_ones", idx), count_w(widths, 0, 72, T1), v.ones);
      ck($sformatf("v%0d_zeros", idx), count_w(widths, 0, 72, T0), 72 - v.ones);
      bad = 0;
      for (int i = 1; i < 72; i++)
        if (rises[i] - rises[i-1] != ((i == 24) ? BP + v.stall : BP)) bad++;
      ck($sformatf("v%0d_spacing_errs", idx), bad, 0);
      ck($sformatf("v%0d_frame_len", idx), done_times[0] - rises[0], v.len);
      ck($sformatf("v%0d_busy_at_done", idx), busy_at_done[0], 0);
      for (int j = 0; j < 3; j++) begin
        ck($sformatf("v%0d_addr%0d_val", idx, j), addr_vals[j], (j + 1) % 3);
        ck($sformatf("v%0d_addr%0d_time", idx, j), addr_times[j], rises[24*j]);
      end
    end
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{72'hFF0000_00FF00_0000AA, 0, 20, 740};
    vecs[1] = '{72'hFFFFFF_FFFFFF_FFFFFF, 0, 72, 740};
    vecs[2] = '{72'h000000_000000_000000, 0, 0, 740};
    vecs[3] = '{72'h123456_800001_0F0F0F, 15, 23, 755};
    mem1 = 24'hA5C33C;
    for (int i = 0; i < NL; i++) mem0[i] = 24'h0;

    repeat (4) @(posedge clk_led);
    #2;
    ck("rst_strand", int'(strand0), 0);
    ck("rst_busy", int'(busy0), 0);
    ck("rst_done", int'(done0), 0);
    ck("rst_addr", int'(bif0.next_led_request_address), 0);
    rst = 1'b0;
    repeat (4) @(posedge clk_led);
    #2;
    ck("idle_busy", int'(busy0), 0);

    for (int i = 0; i < 4; i++) run_vec(i, vecs[i]);

    // Continuous mode: two frames, enable dropped in LED 1 of frame 2.
    for (int i = 0; i < NL; i++) mem0[i] = vecs[0].data[71-24*i -: 24];
    clear_mon();
    @(posedge clk_led); #2;
    en0 = 1'b1;
    wait_q("cont_rise1", 0, 1, 50);
    wait_q("cont_done1", 1, 1, 2000);
    wait_q("cont_led1_f2", 0, 102, 1000);
    en0 = 1'b0;
    wait_q("cont_done2", 1, 2, 2000);
    repeat (40) @(posedge clk_led);
    #2;
    ck("cont_pulses", widths.size(), 144);
    ck("cont_busy_end", int'(busy0), 0);
    if (rises.size() >= 73 && widths.size() >= 144 && done_times.size() >= 2) begin
      ck("cont_restart", rises[72] - done_times[0], 1);
      ck("cont_busy_at_done1", busy_at_done[0], 1);
      ck_data("cont_data2", decode(widths, 72, 72), vecs[0].data);
      ck("cont_len2", done_times[1] - rises[72], 740);
    end

    // Asynchronous reset mid-bit, then restart from LED 0.
    for (int i = 0; i < NL; i++) mem0[i] = vecs[3].data[71-24*i -: 24];
    clear_mon();
    @(posedge clk_led); #2;
    en0 = 1'b1;
    wait_q("arst_reach", 0, 31, 600);
    ck("arst_pre_strand", int'(strand0), 1);
    rst = 1'b1;
    #1;
    ck("arst_strand", int'(strand0), 0);
    ck("arst_busy", int'(busy0), 0);
    ck("arst_addr", int'(bif0.next_led_request_address), 0);
    ck("arst_done", int'(done0), 0);
    repeat (3) @(posedge clk_led);
    #2;
    clear_mon();
    rst = 1'b0;
    wait_q("arst_rise", 0, 1, 50);
    en0 = 1'b0;
    wait_q("arst_frame_done", 1, 1, 2000);
    repeat (5) @(posedge clk_led);
    #2;
    ck("arst_pulses", widths.size(), 72);
    ck("arst_addr_changes", addr_vals.size(), 3);
    if (widths.size() >= 72 && addr_vals.size() >= 1 && done_times.size() >= 1) begin
      ck_data("arst_data", decode(widths, 0, 72), vecs[3].data);
      ck("arst_addr_first", addr_vals[0], 1);
      ck("arst_frame_len", done_times[0] - rises[0], 740);
    end

    // Single-LED strand: address pinned at 0, frame = 240 + 20 cycles.
    clear_mon();
    @(posedge clk_led); #2;
    en1 = 1'b1;
    wait_q("n1_rise", 2, 1, 50);
    en1 = 1'b0;
    wait_q("n1_done", 3, 1, 1000);
    repeat (5) @(posedge clk_led);
    #2;
    ck("n1_pulses", widths1.size(), 24);
    ck("n1_addr_nonzero", addr1_nz, 0);
    ck("n1_done_cycles", done1_times.size(), 1);
    ck("n1_busy_end", int'(busy1), 0);
    if (widths1.size() >= 24 && rises1.size() >= 1 && done1_times.size() >= 1) begin
      ck_data("n1_data", decode(widths1, 0, 24), 72'hA5C33C);
      ck("n1_ones", count_w(widths1, 0, 24, T1), 12);
      ck("n1_frame_len", done1_times[0] - rises1[0], 260);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached, %0d/%0d passed so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
